// File: rtl/ptch_fusion_pkg.sv
// Shared types, default constants and the accumulator saturation helper
// for the pitch fusion integrator.
package ptch_fusion_pkg;

  typedef enum logic {
    CAL = 1'b0,
    RUN = 1'b1
  } state_t;

  localparam logic [15:0] DEF_RT_OFF_C    = 16'h03C2;
  localparam logic [15:0] AZ_OFFSET_C     = 16'hFE80;
  localparam int          ACC_GAIN_C      = 327;
  localparam int          ACC_SHIFT_C     = 13;
  localparam int          FUSION_STEP_C   = 1024;

  // Clamp a sign-extended sum into the signed range of an aw-bit accumulator.
  function automatic logic signed [63:0] sat_acc(input logic signed [63:0] x,
                                                 input int aw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (aw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (aw - 1));
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
  endfunction

endpackage

// File: rtl/ptch_fusion_integrator_cal_avg.sv
// Gyro offset calibration: sums 2^CAL_LOG2 samples and flags the sample
// that completes the set, presenting the rounded-down mean alongside it.
module ptch_cal_avg #(
  parameter int DW       = 16,
  parameter int CAL_LOG2 = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 smp,
  input  logic [DW-1:0]        sample,
  output logic                 done,
  output logic [DW-1:0]        avg
);

  localparam int SW = DW + CAL_LOG2;

  logic [CAL_LOG2-1:0]  cnt;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] sum_nxt;

  assign sum_nxt = sum + SW'($signed(sample));
  assign done    = smp && (cnt == '1);
  assign avg     = DW'(sum_nxt >>> CAL_LOG2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sum <= '0;
    end else if (clr || done) begin
      cnt <= '0;
      sum <= '0;
    end else if (smp) begin
      cnt <= cnt + 1'b1;
      sum <= sum_nxt;
    end
  end

endmodule

// File: rtl/ptch_fusion_integrator.sv
// Pitch integrator: learns the gyro rate offset, then integrates the
// compensated rate with a fixed-step pull toward the accelerometer pitch.
module ptch_fusion_integrator
  import ptch_fusion_pkg::*;
#(
  parameter int          DW          = 16,
  parameter int          INT_FRAC    = 11,
  parameter int          CAL_LOG2    = 8,
  parameter logic [15:0] DEF_RT_OFF  = DEF_RT_OFF_C,
  parameter logic [15:0] AZ_OFFSET   = AZ_OFFSET_C,
  parameter int          ACC_GAIN    = ACC_GAIN_C,
  parameter int          ACC_SHIFT   = ACC_SHIFT_C,
  parameter int          FUSION_STEP = FUSION_STEP_C
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vld,
  input  logic          cal_req,
  input  logic [DW-1:0] ptch_rt,
  input  logic [DW-1:0] AZ,
  output logic [DW-1:0] ptch,
  output logic          ptch_vld,
  output logic          cal_done,
  output logic [DW-1:0] rt_offset
);

  localparam int AW = DW + INT_FRAC;
  localparam int PW = DW + 17;
  localparam logic signed [15:0]   GAIN_S = 16'(ACC_GAIN);
  localparam logic signed [AW-1:0] FUS_P  = AW'(FUSION_STEP);
  localparam logic signed [AW-1:0] FUS_N  = -FUS_P;

  state_t               state, state_nxt;
  logic signed [AW-1:0] acc, acc_nxt;
  logic [DW-1:0]        rt_offset_nxt;
  logic                 ptch_vld_nxt;

  logic                 cal_smp, cal_fin;
  logic [DW-1:0]        cal_avg;

  logic signed [DW-1:0] ptch_s, ptch_acc, rate;
  logic signed [DW:0]   az_diff;
  logic signed [PW-1:0] az_prod;
  logic signed [AW-1:0] fus, acc_sat;
  logic signed [AW+1:0] acc_sum;

  assign cal_smp = vld && !cal_req && (state == CAL);

  ptch_cal_avg #(.DW(DW), .CAL_LOG2(CAL_LOG2)) u_cal (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cal_req),
    .smp    (cal_smp),
    .sample (ptch_rt),
    .done   (cal_fin),
    .avg    (cal_avg)
  );

  assign ptch     = acc[AW-1:INT_FRAC];
  assign ptch_s   = $signed(ptch);
  assign cal_done = (state == RUN);

  // Accelerometer pitch estimate; difference kept one bit wider so it cannot wrap.
  assign az_diff  = (DW+1)'($signed(AZ)) - (DW+1)'($signed(AZ_OFFSET[DW-1:0]));
  assign az_prod  = $signed(PW'(az_diff)) * $signed(PW'(GAIN_S));
  assign ptch_acc = DW'(az_prod >>> ACC_SHIFT);
  assign fus      = (ptch_acc > ptch_s) ? FUS_P : FUS_N;

  assign rate     = $signed(ptch_rt - rt_offset);
  assign acc_sum  = (AW+2)'(acc) - (AW+2)'(rate) + (AW+2)'(fus);
  assign acc_sat  = AW'(sat_acc(64'(acc_sum), AW));

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    rt_offset_nxt = rt_offset;
    ptch_vld_nxt  = 1'b0;
    if (cal_req) begin
      state_nxt = CAL;
      acc_nxt   = '0;
    end else begin
      case (state)
        CAL: if (cal_fin) begin
          rt_offset_nxt = cal_avg;
          acc_nxt       = '0;
          state_nxt     = RUN;
        end
        RUN: if (vld) begin
          acc_nxt      = acc_sat;
          ptch_vld_nxt = 1'b1;
        end
        default: state_nxt = CAL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CAL;
      acc       <= '0;
      rt_offset <= DEF_RT_OFF[DW-1:0];
      ptch_vld  <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      rt_offset <= rt_offset_nxt;
      ptch_vld  <= ptch_vld_nxt;
    end
  end

endmodule
